uart_frame_check: RTL and testbench
===================================

UART_FRAME_CHECK -- requirements
Module: uart_frame_check

Interface
REQ-001 Parameter DATA_WIDTH, default 8, meaning data bits per frame; legal range 5..9.
REQ-002 Parameter STOP_BITS, default 1, meaning stop bits checked per frame; legal values 1 or 2.
REQ-003 Parameter CNT_WIDTH, default 8, meaning width of each error counter.
REQ-004 Port clk  input  1  system clock; all state changes on rising edge.
REQ-005 Port rst  input  1  reset; asynchronous, active-high.
REQ-006 Port frame_start  input  1  one-cycle pulse: start bit detected.
REQ-007 Port bit_valid  input  1  one-cycle strobe: sampled_bit holds a new mid-bit sample.
REQ-008 Port sampled_bit  input  1  sampled serial bit value.
REQ-009 Port PAR_EN  input  1  parity bit present in frame when 1.
REQ-010 Port PAR_TYP  input  2  00 even, 01 odd, 10 mark (always 1), 11 space (always 0).
REQ-011 Port cnt_clr  input  1  synchronous clear of both error counters.
REQ-012 Port data_out  output  DATA_WIDTH  last received data word, LSB first on line.
REQ-013 Port data_valid  output  1  one-cycle pulse: frame complete, data_out/flags updated.
REQ-014 Port par_err  output  1  parity mismatch in last frame.
REQ-015 Port stp_err  output  1  any stop bit sampled 0 in last frame.
REQ-016 Port par_err_cnt  output  CNT_WIDTH  saturating count of frames with par_err.
REQ-017 Port stp_err_cnt  output  CNT_WIDTH  saturating count of frames with stp_err.
REQ-018 Port busy  output  1  high in any state other than IDLE.

Function
REQ-019 FSM states: IDLE, DATA, PARITY, STOP; bit counter sized for max(DATA_WIDTH, STOP_BITS).
REQ-020 IDLE: frame_start -> DATA, bit counter cleared, running parity cleared, PAR_EN/PAR_TYP latched for the whole frame.
REQ-021 bit_valid coincident with frame_start is ignored (it is the start bit).
REQ-022 DATA: each bit_valid shifts sampled_bit into shift register MSB, shifting right (LSB-first reception), XORs it into running parity, increments counter.
REQ-023 DATA: on bit_valid number DATA_WIDTH -> PARITY if latched PAR_EN=1, else STOP; counter cleared.
REQ-024 PARITY: on bit_valid compute expected bit: even = running parity, odd = ~running parity, mark = 1, space = 0; frame parity error = (sampled_bit != expected); -> STOP.
REQ-025 STOP: each bit_valid with sampled_bit=0 sets frame stop error; after bit_valid number STOP_BITS -> IDLE.
REQ-026 On the clock edge leaving STOP: data_out <= shift register, par_err <= frame parity error (0 if PAR_EN=0), stp_err <= frame stop error, data_valid=1 for exactly the following cycle.
REQ-027 Latency: data_valid high in the cycle after the clock edge sampling the last stop-bit bit_valid.
REQ-028 data_out, par_err, stp_err hold until next data_valid; unchanged by aborted frames.
REQ-029 frame_start while not IDLE: abort current frame (no data_valid, no counter update), restart at DATA as in REQ-020.
REQ-030 par_err_cnt/stp_err_cnt increment by 1 in the data_valid cycle of the corresponding flag; saturate at all-ones.
REQ-031 cnt_clr has priority over increment in the same cycle; counters read 0 after it.
REQ-032 Cycles without bit_valid change no state; PAR_EN/PAR_TYP changes mid-frame have no effect.

Reset
REQ-033 rst asserted at any time, including mid-frame: state IDLE, counter, shift register, data_out=0, data_valid=0, par_err=0, stp_err=0, both counts=0, busy=0, immediately (asynchronously).
REQ-034 After rst deasserts, the block waits for a fresh frame_start; bit_valid in IDLE is ignored.

Verification
REQ-035 DATA_WIDTH=8, STOP_BITS=1, PAR_EN=1, PAR_TYP=00; frame 0xA5, parity bit 0, stop 1 -> data_out=0xA5, par_err=0, stp_err=0, one-cycle data_valid.
REQ-036 Same frame with parity bit 1 -> par_err=1, par_err_cnt 0->1; then PAR_TYP=01 with parity bit 1 -> par_err=0.
REQ-037 PAR_TYP=10, 0x00 with parity bit 0 -> par_err=1; PAR_EN=0, 0x3C, stop 0 -> par_err=0, stp_err=1, stp_err_cnt increments.
REQ-038 STOP_BITS=2, DATA_WIDTH=7: 0x55, stops 1 then 0 -> data_out=0x55, stp_err=1; data_valid only after second stop bit.
REQ-039 frame_start after 4 data bits, then full frame 0x81 -> single data_valid, data_out=0x81; rst mid-frame -> all outputs 0, no data_valid.
REQ-040 CNT_WIDTH=2: five parity-error frames -> par_err_cnt=3; cnt_clr coincident with sixth data_valid -> par_err_cnt=0.

Source files
------------

// File: rtl/uart_frame_check.sv
// UART receive frame checker: assembles data bits from mid-bit samples, checks
// parity and stop bits, and keeps saturating per-frame error counters.
module uart_frame_check #(
    parameter int DATA_WIDTH = 8,
    parameter int STOP_BITS  = 1,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  frame_start,
    input  logic                  bit_valid,
    input  logic                  sampled_bit,
    input  logic                  PAR_EN,
    input  logic [1:0]            PAR_TYP,
    input  logic                  cnt_clr,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err,
    output logic [CNT_WIDTH-1:0]  par_err_cnt,
    output logic [CNT_WIDTH-1:0]  stp_err_cnt,
    output logic                  busy
);

    localparam int MAXB = (DATA_WIDTH > STOP_BITS) ? DATA_WIDTH : STOP_BITS;
    localparam int BW   = $clog2(MAXB + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t                state, state_nxt;
    logic [BW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  run_par;
    logic                  frm_par_err;
    logic                  frm_stp_err;
    logic                  par_en_q;
    logic [1:0]            par_typ_q;
    logic                  last_data;
    logic                  last_stop;
    logic                  exp_par;
    logic                  done;

    assign last_data = (bit_cnt == BW'(DATA_WIDTH - 1));
    assign last_stop = (bit_cnt == BW'(STOP_BITS - 1));
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // frame_start always restarts, so it also serves as the abort path
    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        if (frame_start) begin
            state_nxt = DATA;
        end else if (bit_valid) begin
            case (state)
                DATA:    if (last_data) state_nxt = par_en_q ? PARITY : STOP;
                PARITY:  state_nxt = STOP;
                STOP: begin
                    if (last_stop) begin
                        state_nxt = IDLE;
                        done      = 1'b1;
                    end
                end
                default: state_nxt = state;
            endcase
        end
    end

    always_comb begin
        case (par_typ_q)
            2'b00:   exp_par = run_par;
            2'b01:   exp_par = ~run_par;
            2'b10:   exp_par = 1'b1;
            default: exp_par = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt     <= '0;
            shreg       <= '0;
            run_par     <= 1'b0;
            frm_par_err <= 1'b0;
            frm_stp_err <= 1'b0;
            par_en_q    <= 1'b0;
            par_typ_q   <= 2'b00;
        end else if (frame_start) begin
            bit_cnt     <= '0;
            run_par     <= 1'b0;
            frm_par_err <= 1'b0;
            frm_stp_err <= 1'b0;
            par_en_q    <= PAR_EN;
            par_typ_q   <= PAR_TYP;
        end else if (bit_valid) begin
            case (state)
                DATA: begin
                    shreg   <= {sampled_bit, shreg[DATA_WIDTH-1:1]};
                    run_par <= run_par ^ sampled_bit;
                    bit_cnt <= last_data ? '0 : bit_cnt + BW'(1);
                end
                PARITY: frm_par_err <= (sampled_bit != exp_par);
                STOP: begin
                    if (!sampled_bit) frm_stp_err <= 1'b1;
                    bit_cnt <= last_stop ? '0 : bit_cnt + BW'(1);
                end
                default: ;
            endcase
        end
    end

    // the last stop sample is folded in directly since frm_stp_err updates on the same edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
        end else begin
            data_valid <= done;
            if (done) begin
                data_out <= shreg;
                par_err  <= frm_par_err & par_en_q;
                stp_err  <= frm_stp_err | ~sampled_bit;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_err_cnt <= '0;
            stp_err_cnt <= '0;
        end else if (cnt_clr) begin
            par_err_cnt <= '0;
            stp_err_cnt <= '0;
        end else if (data_valid) begin
            if (par_err && par_err_cnt != '1) par_err_cnt <= par_err_cnt + CNT_WIDTH'(1);
            if (stp_err && stp_err_cnt != '1) stp_err_cnt <= stp_err_cnt + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_uart_frame_check.sv
// Directed bench: three configurations share one stimulus stream, each test
// checks only the instance whose parameters it targets.
module tb_uart_frame_check;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic frame_start = 1'b0, bit_valid = 1'b0, sampled_bit = 1'b1;
    logic PAR_EN = 1'b0, cnt_clr = 1'b0;
    logic [1:0] PAR_TYP = 2'b00;

    logic [7:0] data_out_a, par_cnt_a, stp_cnt_a;
    logic       dv_a, pe_a, se_a, busy_a;
    logic [6:0] data_out_b;
    logic [7:0] par_cnt_b, stp_cnt_b;
    logic       dv_b, pe_b, se_b, busy_b;
    logic [7:0] data_out_c;
    logic [1:0] par_cnt_c, stp_cnt_c;
    logic       dv_c, pe_c, se_c, busy_c;

    int checks = 0, failures = 0;
    int dv_cnt_a = 0, dv_cnt_b = 0;

    always #5 clk = ~clk;

    always @(negedge clk) begin
        dv_cnt_a += int'(dv_a);
        dv_cnt_b += int'(dv_b);
    end

    uart_frame_check #(.DATA_WIDTH(8), .STOP_BITS(1), .CNT_WIDTH(8)) dut_a (
        .clk(clk), .rst(rst), .frame_start(frame_start), .bit_valid(bit_valid),
        .sampled_bit(sampled_bit), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .cnt_clr(cnt_clr),
        .data_out(data_out_a), .data_valid(dv_a), .par_err(pe_a), .stp_err(se_a),
        .par_err_cnt(par_cnt_a), .stp_err_cnt(stp_cnt_a), .busy(busy_a));

    uart_frame_check #(.DATA_WIDTH(7), .STOP_BITS(2), .CNT_WIDTH(8)) dut_b (
        .clk(clk), .rst(rst), .frame_start(frame_start), .bit_valid(bit_valid),
        .sampled_bit(sampled_bit), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .cnt_clr(cnt_clr),
        .data_out(data_out_b), .data_valid(dv_b), .par_err(pe_b), .stp_err(se_b),
        .par_err_cnt(par_cnt_b), .stp_err_cnt(stp_cnt_b), .busy(busy_b));

    uart_frame_check #(.DATA_WIDTH(8), .STOP_BITS(1), .CNT_WIDTH(2)) dut_c (
        .clk(clk), .rst(rst), .frame_start(frame_start), .bit_valid(bit_valid),
        .sampled_bit(sampled_bit), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .cnt_clr(cnt_clr),
        .data_out(data_out_c), .data_valid(dv_c), .par_err(pe_c), .stp_err(se_c),
        .par_err_cnt(par_cnt_c), .stp_err_cnt(stp_cnt_c), .busy(busy_c));

    // start pulse carries a coincident bit_valid which must be ignored
    task automatic pulse_start();
        @(negedge clk);
        frame_start = 1'b1; bit_valid = 1'b1; sampled_bit = 1'b1;
        @(negedge clk);
        frame_start = 1'b0; bit_valid = 1'b0;
    endtask

    // one idle cycle, then a one-cycle strobe; returns on the negedge after it was taken
    task automatic send_bit(input logic b);
        @(negedge clk);
        bit_valid = 1'b1; sampled_bit = b;
        @(negedge clk);
        bit_valid = 1'b0; sampled_bit = 1'b1;
    endtask

    task automatic send_frame(input logic [8:0] d, input int nd, input logic pe,
                              input logic pb, input logic [1:0] stops, input int ns);
        pulse_start();
        for (int i = 0; i < nd; i++) send_bit(d[i]);
        if (pe) send_bit(pb);
        for (int i = 0; i < ns; i++) send_bit(stops[i]);
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({data_out_a, dv_a, pe_a, se_a, par_cnt_a, stp_cnt_a, busy_a} !== 29'd0) begin
            failures++;
            $display("FAIL reset_a: got %h/%b/%b/%b/%h/%h/%b, want all 0",
                     data_out_a, dv_a, pe_a, se_a, par_cnt_a, stp_cnt_a, busy_a);
        end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_parity_even();
        PAR_EN = 1'b1; PAR_TYP = 2'b00;
        send_frame(9'h0A5, 8, 1'b1, 1'b0, 2'b11, 1);
        checks++;
        if ({dv_a, data_out_a, pe_a, se_a} !== {1'b1, 8'hA5, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL even_ok: dv=%b data=%h pe=%b se=%b, want 1 a5 0 0", dv_a, data_out_a, pe_a, se_a);
        end
        @(negedge clk);
        checks++;
        if (dv_a !== 1'b0) begin
            failures++;
            $display("FAIL dv_one_cycle: dv=%b, want 0", dv_a);
        end
        send_frame(9'h0A5, 8, 1'b1, 1'b1, 2'b11, 1);
        checks++;
        if ({dv_a, pe_a, par_cnt_a} !== {1'b1, 1'b1, 8'd0}) begin
            failures++;
            $display("FAIL even_bad: dv=%b pe=%b cnt=%0d, want 1 1 0", dv_a, pe_a, par_cnt_a);
        end
        @(negedge clk);
        checks++;
        if (par_cnt_a !== 8'd1) begin
            failures++;
            $display("FAIL par_cnt_inc: got %0d, want 1", par_cnt_a);
        end
    endtask

    task automatic test_parity_types();
        PAR_TYP = 2'b01;
        send_frame(9'h0A5, 8, 1'b1, 1'b1, 2'b11, 1);
        checks++;
        if ({dv_a, pe_a} !== 2'b10) begin
            failures++;
            $display("FAIL odd_ok: dv=%b pe=%b, want 1 0", dv_a, pe_a);
        end
        PAR_TYP = 2'b10;
        send_frame(9'h000, 8, 1'b1, 1'b0, 2'b11, 1);
        checks++;
        if ({dv_a, data_out_a, pe_a} !== {1'b1, 8'h00, 1'b1}) begin
            failures++;
            $display("FAIL mark_bad: dv=%b data=%h pe=%b, want 1 00 1", dv_a, data_out_a, pe_a);
        end
        @(negedge clk);
        checks++;
        if (par_cnt_a !== 8'd2) begin
            failures++;
            $display("FAIL par_cnt_2: got %0d, want 2", par_cnt_a);
        end
    endtask

    task automatic test_stop_error();
        PAR_EN = 1'b0; PAR_TYP = 2'b00;
        pulse_start();
        PAR_EN = 1'b1;  // latched value governs the frame, not this one
        for (int i = 0; i < 8; i++) send_bit(i == 2 || i == 3 || i == 4 || i == 5);
        send_bit(1'b0);
        checks++;
        if ({dv_a, data_out_a, pe_a, se_a, stp_cnt_a} !== {1'b1, 8'h3C, 1'b0, 1'b1, 8'd0}) begin
            failures++;
            $display("FAIL stop_bad: dv=%b data=%h pe=%b se=%b cnt=%0d, want 1 3c 0 1 0",
                     dv_a, data_out_a, pe_a, se_a, stp_cnt_a);
        end
        @(negedge clk);
        checks++;
        if ({stp_cnt_a, par_cnt_a} !== {8'd1, 8'd2}) begin
            failures++;
            $display("FAIL stp_cnt_inc: stp=%0d par=%0d, want 1 2", stp_cnt_a, par_cnt_a);
        end
        PAR_EN = 1'b0;
    endtask

    task automatic test_abort_and_reset();
        int base;
        #1 base = dv_cnt_a;
        pulse_start();
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        send_frame(9'h081, 8, 1'b0, 1'b0, 2'b11, 1);
        checks++;
        if ({dv_a, data_out_a, se_a} !== {1'b1, 8'h81, 1'b0}) begin
            failures++;
            $display("FAIL abort_frame: dv=%b data=%h se=%b, want 1 81 0", dv_a, data_out_a, se_a);
        end
        @(negedge clk); #1;
        checks++;
        if (dv_cnt_a - base !== 1) begin
            failures++;
            $display("FAIL abort_single_dv: got %0d pulses, want 1", dv_cnt_a - base);
        end
        #1 base = dv_cnt_a;
        pulse_start();
        for (int i = 0; i < 3; i++) send_bit(1'b0);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({data_out_a, dv_a, pe_a, se_a, par_cnt_a, stp_cnt_a, busy_a} !== 29'd0) begin
            failures++;
            $display("FAIL rst_mid: got %h/%b/%b/%b/%h/%h/%b, want all 0",
                     data_out_a, dv_a, pe_a, se_a, par_cnt_a, stp_cnt_a, busy_a);
        end
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 9; i++) send_bit(1'b1);
        #1;
        checks++;
        if ({busy_a, dv_cnt_a - base} !== {1'b0, 32'd0}) begin
            failures++;
            $display("FAIL idle_ignore: busy=%b pulses=%0d, want 0 0", busy_a, dv_cnt_a - base);
        end
    endtask

    task automatic test_two_stop();
        int base;
        PAR_EN = 1'b0;
        #1 base = dv_cnt_b;
        pulse_start();
        for (int i = 0; i < 7; i++) send_bit(i[0] == 1'b0);
        send_bit(1'b1);
        #1;
        checks++;
        if ({busy_b, dv_cnt_b - base} !== {1'b1, 32'd0}) begin
            failures++;
            $display("FAIL stop1_early: busy=%b pulses=%0d, want 1 0", busy_b, dv_cnt_b - base);
        end
        send_bit(1'b0);
        checks++;
        if ({dv_b, data_out_b, se_b, pe_b} !== {1'b1, 7'h55, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL two_stop: dv=%b data=%h se=%b pe=%b, want 1 55 1 0", dv_b, data_out_b, se_b, pe_b);
        end
    endtask

    task automatic test_saturate_clear();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        PAR_EN = 1'b1; PAR_TYP = 2'b00;
        for (int f = 0; f < 5; f++) begin
            send_frame(9'h0A5, 8, 1'b1, 1'b1, 2'b11, 1);
            @(negedge clk);
            if (f == 2 || f == 4) begin
                checks++;
                if (par_cnt_c !== 2'd3) begin
                    failures++;
                    $display("FAIL sat_cnt_f%0d: got %0d, want 3", f, par_cnt_c);
                end
            end
        end
        send_frame(9'h0A5, 8, 1'b1, 1'b1, 2'b11, 1);
        cnt_clr = 1'b1;
        @(negedge clk); cnt_clr = 1'b0;
        checks++;
        if ({par_cnt_c, stp_cnt_c} !== 4'd0) begin
            failures++;
            $display("FAIL clr_priority: par=%0d stp=%0d, want 0 0", par_cnt_c, stp_cnt_c);
        end
    endtask

    initial begin
        test_reset();
        test_parity_even();
        test_parity_types();
        test_stop_error();
        test_abort_and_reset();
        test_two_stop();
        test_saturate_clear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
